// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS-I opcode/funct constants, ALU codes and decode control bundle
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
                         OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f,
                         OP_COP0    = 6'h10,
                         OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA     = 6'h03, F_SLLV  = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR      = 6'h08, F_JALR  = 6'h09,
                         F_SYSCALL = 6'h0c, F_BREAK = 6'h0d,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO    = 6'h12, F_MTLO  = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV    = 6'h1a, F_DIVU  = 6'h1b,
                         F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB     = 6'h22, F_SUBU  = 6'h23,
                         F_AND  = 6'h24, F_OR   = 6'h25, F_XOR     = 6'h26, F_NOR   = 6'h27,
                         F_SLT  = 6'h2a, F_SLTU = 6'h2b, F_ERET    = 6'h18;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_CO = 5'h10;

  localparam logic [4:0] ALU_NOP  = 5'd0,  ALU_ADD  = 5'd1,  ALU_ADDU  = 5'd2,  ALU_SUB  = 5'd3,
                         ALU_SUBU = 5'd4,  ALU_AND  = 5'd5,  ALU_OR    = 5'd6,  ALU_XOR  = 5'd7,
                         ALU_NOR  = 5'd8,  ALU_SLT  = 5'd9,  ALU_SLTU  = 5'd10, ALU_SLL  = 5'd11,
                         ALU_SRL  = 5'd12, ALU_SRA  = 5'd13, ALU_SLLV  = 5'd14, ALU_SRLV = 5'd15,
                         ALU_SRAV = 5'd16, ALU_LUI  = 5'd17, ALU_MULT  = 5'd18, ALU_MULTU = 5'd19,
                         ALU_DIV  = 5'd20, ALU_DIVU = 5'd21;

  typedef struct packed {
    logic [4:0] alucontrol;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       savepc;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       jump;
    logic       jr;
    logic       inst_err;
    logic       brk;
    logic       syscall;
    logic       eret;
    logic       mfc0;
    logic       mtc0;
    logic       hilo_we;
    logic       hilo_rd;
  } decode_ctrl_t;

  localparam decode_ctrl_t CTRL_NOP = '0;

  function automatic logic [4:0] funct_alu(input logic [5:0] funct);
    case (funct)
      F_ADD:   return ALU_ADD;
      F_ADDU:  return ALU_ADDU;
      F_SUB:   return ALU_SUB;
      F_SUBU:  return ALU_SUBU;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      F_SLTU:  return ALU_SLTU;
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      F_SRA:   return ALU_SRA;
      F_SLLV:  return ALU_SLLV;
      F_SRLV:  return ALU_SRLV;
      F_SRAV:  return ALU_SRAV;
      F_MULT:  return ALU_MULT;
      F_MULTU: return ALU_MULTU;
      F_DIV:   return ALU_DIV;
      F_DIVU:  return ALU_DIVU;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic [4:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ADDI:  return ALU_ADD;
      OP_ADDIU: return ALU_ADDU;
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/inst_decode_comb.sv
// rtl/inst_decode_comb.sv - combinational MIPS-I decoder; DECODE_HILO_EN enables HI/LO ops
module inst_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]  inst,
  output decode_ctrl_t ctrl
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  decode_ctrl_t c;
  logic err;
  logic unused_fields;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign funct = inst[5:0];
  assign unused_fields = &{1'b0, inst[15:6]};

  always_comb begin
    c   = CTRL_NOP;
    err = 1'b0;
    // the all-zero word is SLL $0,$0,0 but is treated as a true bubble
    if (inst != 32'h0) begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
              c.alucontrol = funct_alu(funct);
              c.regwrite   = 1'b1;
              c.regdst     = 1'b1;
            end
            F_JR: c.jr = 1'b1;
            F_JALR: begin
              c.jr       = 1'b1;
              c.savepc   = 1'b1;
              c.regwrite = 1'b1;
              c.regdst   = 1'b1;
            end
            F_SYSCALL: c.syscall = 1'b1;
            F_BREAK:   c.brk     = 1'b1;
`ifdef DECODE_HILO_EN
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              c.alucontrol = funct_alu(funct);
              c.hilo_we    = 1'b1;
            end
            F_MTHI, F_MTLO: c.hilo_we = 1'b1;
            F_MFHI, F_MFLO: begin
              c.hilo_rd  = 1'b1;
              c.regwrite = 1'b1;
              c.regdst   = 1'b1;
            end
`endif
            default: err = 1'b1;
          endcase
        end
        OP_REGIMM: begin
          case (rt)
            RT_BLTZ, RT_BGEZ: c.branch = 1'b1;
            RT_BLTZAL, RT_BGEZAL: begin
              c.branch   = 1'b1;
              c.savepc   = 1'b1;
              c.regwrite = 1'b1;
            end
            default: err = 1'b1;
          endcase
        end
        OP_J: c.jump = 1'b1;
        OP_JAL: begin
          c.jump     = 1'b1;
          c.savepc   = 1'b1;
          c.regwrite = 1'b1;
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c.branch = 1'b1;
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          c.alucontrol = imm_alu(op);
          c.alusrc     = 1'b1;
          c.regwrite   = 1'b1;
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          c.alucontrol = ALU_ADDU;
          c.alusrc     = 1'b1;
          c.regwrite   = 1'b1;
          c.memtoreg   = 1'b1;
          c.memread    = 1'b1;
        end
        OP_SB, OP_SH, OP_SW: begin
          c.alucontrol = ALU_ADDU;
          c.alusrc     = 1'b1;
          c.memwrite   = 1'b1;
        end
        OP_COP0: begin
          case (rs)
            RS_MFC0: begin
              c.mfc0     = 1'b1;
              c.regwrite = 1'b1;
            end
            RS_MTC0: c.mtc0 = 1'b1;
            RS_CO: begin
              if (funct == F_ERET) c.eret = 1'b1;
              else                 err    = 1'b1;
            end
            default: err = 1'b1;
          endcase
        end
        default: err = 1'b1;
      endcase
    end
    if (err) begin
      c          = CTRL_NOP;
      c.inst_err = 1'b1;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - buffered decode stage: FIFO, registered decode output, delay-slot tag, flush
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output decode_ctrl_t             out_ctrl,
  output logic                     out_delayslot,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic             full, empty, push, load, ds_pending;
  logic [31:0]      head_inst;
  decode_ctrl_t     head_ctrl;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign load     = (!out_valid || out_ready) && !empty;
  assign count    = wr_ptr - rd_ptr;
  assign head_inst = inst_mem[rd_ptr[AW-1:0]];

  inst_decode_comb u_dec (
    .inst (head_inst),
    .ctrl (head_ctrl)
  );

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
      inst_mem[wr_ptr[AW-1:0]] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst      <= '0;
      out_ctrl      <= CTRL_NOP;
      out_delayslot <= 1'b0;
      ds_pending    <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      ds_pending <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        out_valid     <= 1'b1;
        out_pc        <= pc_mem[rd_ptr[AW-1:0]];
        out_inst      <= head_inst;
        out_ctrl      <= head_ctrl;
        out_delayslot <= ds_pending;
        // a control transfer in a delay slot re-arms the tag for its own slot
        ds_pending    <= head_ctrl.branch | head_ctrl.jump | head_ctrl.jr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue (table vectors, sequences, random vs model)
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  localparam logic [22:0] C_ALUSRC = 23'd1 << 17, C_REGDST = 23'd1 << 16, C_REGWRITE = 23'd1 << 15,
                          C_SAVEPC = 23'd1 << 14, C_MEMTOREG = 23'd1 << 13, C_MEMWRITE = 23'd1 << 12,
                          C_MEMREAD = 23'd1 << 11, C_BRANCH = 23'd1 << 10, C_JUMP = 23'd1 << 9,
                          C_JR = 23'd1 << 8, C_ERR = 23'd1 << 7, C_BRK = 23'd1 << 6,
                          C_SYSCALL = 23'd1 << 5, C_ERET = 23'd1 << 4, C_MFC0 = 23'd1 << 3,
                          C_MTC0 = 23'd1 << 2, C_HILO_WE = 23'd1 << 1, C_HILO_RD = 23'd1;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_delayslot;
  logic [PC_W-1:0] in_pc = '0, out_pc;
  logic [31:0] in_inst = '0, out_inst;
  decode_ctrl_t out_ctrl;
  logic [$clog2(DEPTH):0] count;

  int errors = 0, checks = 0;

  typedef struct {
    logic [31:0] inst;
    logic [22:0] ctrl;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [22:0] ctrl;
  } ent_t;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_ctrl(out_ctrl), .out_delayslot(out_delayslot), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] alu(input logic [4:0] code);
    return {code, 18'b0};
  endfunction

  function automatic void add(input logic [31:0] inst, input logic [22:0] ctrl);
    vec_t v;
    v.inst = inst;
    v.ctrl = ctrl;
    vecs.push_back(v);
  endfunction

  ent_t mq[$];
  ent_t m_out;
  bit   m_ov, m_ds, m_dsp;

  initial begin
    logic [31:0] pcs[$];
    int n;
    bit seen;
    logic [31:0] pc_ctr;

    add(32'h00851021, alu(ALU_ADDU) | C_REGWRITE | C_REGDST);
    add(32'h00000000, 23'h0);
    add(32'h42000018, C_ERET);
    add(32'hFC000000, C_ERR);
    add(32'h10000003, C_BRANCH);
    add(32'h24020001, alu(ALU_ADDU) | C_ALUSRC | C_REGWRITE);
    add(32'h8C820004, alu(ALU_ADDU) | C_ALUSRC | C_REGWRITE | C_MEMTOREG | C_MEMREAD);
    add(32'hAC820004, alu(ALU_ADDU) | C_ALUSRC | C_MEMWRITE);
    add(32'h0C000010, C_JUMP | C_SAVEPC | C_REGWRITE);
    add(32'h08000010, C_JUMP);
    add(32'h03E00008, C_JR);
    add(32'h04110002, C_BRANCH | C_SAVEPC | C_REGWRITE);
    add(32'h0000000C, C_SYSCALL);
    add(32'h0000000D, C_BRK);
    add(32'h40026000, C_MFC0 | C_REGWRITE);
    add(32'h40826000, C_MTC0);
    add(32'h42000001, C_ERR);
    add(32'h0000003F, C_ERR);
    add(32'h3C011234, alu(ALU_LUI) | C_ALUSRC | C_REGWRITE);
    add(32'h00021080, alu(ALU_SLL) | C_REGWRITE | C_REGDST);
`ifdef DECODE_HILO_EN
    add(32'h00850018, alu(ALU_MULT) | C_HILO_WE);
    add(32'h0085001B, alu(ALU_DIVU) | C_HILO_WE);
    add(32'h00001010, C_HILO_RD | C_REGWRITE | C_REGDST);
`else
    add(32'h00850018, C_ERR);
    add(32'h0085001B, C_ERR);
    add(32'h00001010, C_ERR);
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_outs", 128'({out_pc, out_inst, out_ctrl, out_delayslot}), 128'(0));

    in_valid = 1'b1; in_pc = 32'hBFC00000; in_inst = 32'h00851021;
    tick();
    in_valid = 1'b0;
    chk("addu_k_count", 128'({out_valid, count}), 128'({1'b0, 3'd1}));
    tick();
    chk("addu_valid", 128'(out_valid), 128'(1'b1));
    chk("addu_ctrl", 128'(out_ctrl), 128'(alu(ALU_ADDU) | C_REGWRITE | C_REGDST));
    chk("addu_pc_count", 128'({out_pc, count}), 128'({32'hBFC00000, 3'd0}));
    tick();

    in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h10000003;
    tick();
    in_pc = 32'h104; in_inst = 32'h24020001;
    tick();
    chk("ds_beq", 128'({out_valid, out_inst, out_delayslot}), 128'({1'b1, 32'h10000003, 1'b0}));
    in_pc = 32'h108; in_inst = 32'h00851021;
    tick();
    in_valid = 1'b0;
    chk("ds_addiu", 128'({out_valid, out_inst, out_delayslot}), 128'({1'b1, 32'h24020001, 1'b1}));
    tick();
    chk("ds_third", 128'({out_valid, out_inst, out_delayslot}), 128'({1'b1, 32'h00851021, 1'b0}));
    tick();

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * i); in_inst = 32'h24020001;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_full", 128'({out_valid, in_ready, count}), 128'({1'b1, 1'b0, 3'd4}));
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
      if (out_valid) begin
        pcs.push_back(out_pc);
        n++;
      end
      tick();
    end
    chk("bp_drained", 128'(n), 128'(5));
    for (int i = 0; i < pcs.size(); i++)
      chk("bp_order", 128'(pcs[i]), 128'(32'h1000 + 32'(4 * i)));
    chk("bp_empty", 128'({out_valid, count}), 128'(0));

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h2000 + 32'(4 * i); in_inst = 32'h00851021;
      tick();
    end
    chk("fl_pre", 128'({out_valid, count}), 128'({1'b1, 3'd3}));
    flush = 1'b1; in_pc = 32'hDEAD0000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_post", 128'({out_valid, in_ready, count}), 128'({1'b0, 1'b1, 3'd0}));
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("fl_dropped", 128'(seen), 128'(1'b0));

    foreach (vecs[i]) begin
      in_valid = 1'b1; in_pc = 32'h3000 + 32'(4 * i); in_inst = vecs[i].inst;
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("dec_%08h", vecs[i].inst), 128'({out_valid, out_inst, out_ctrl}),
          128'({1'b1, vecs[i].inst, vecs[i].ctrl}));
    end

    flush = 1'b1;
    tick();
    flush = 1'b0;
    mq.delete(); m_ov = 0; m_ds = 0; m_dsp = 0;
    pc_ctr = 32'h8000_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int idx;
      bit iv, orr, fl, acc;
      ent_t e;
      iv  = $urandom_range(0, 3) != 0;
      orr = $urandom_range(0, 2) != 0;
      fl  = $urandom_range(0, 63) == 0;
      idx = $urandom_range(0, vecs.size() - 1);
      in_valid = iv; out_ready = orr; flush = fl;
      in_pc = pc_ctr; in_inst = vecs[idx].inst;
      checks++;
      if (in_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_in_ready: got %0b at cycle %0d", in_ready, cyc);
      end
      tick();
      if (fl) begin
        mq.delete(); m_ov = 0; m_dsp = 0;
      end else begin
        acc = iv && (mq.size() < DEPTH);
        if ((!m_ov || orr) && mq.size() > 0) begin
          m_out = mq.pop_front();
          m_ov  = 1;
          m_ds  = m_dsp;
          m_dsp = m_out.ctrl[10] | m_out.ctrl[9] | m_out.ctrl[8];
        end else if (orr) begin
          m_ov = 0;
        end
        if (acc) begin
          e.pc = pc_ctr; e.inst = vecs[idx].inst; e.ctrl = vecs[idx].ctrl;
          mq.push_back(e);
          pc_ctr += 4;
        end
      end
      checks++;
      if ({out_valid, count} !== {m_ov, 3'(mq.size())}) begin
        errors++;
        $display("FAIL rand_state: got %0h expected %0h at cycle %0d",
                 {out_valid, count}, {m_ov, 3'(mq.size())}, cyc);
      end
      if (m_ov) begin
        checks++;
        if ({out_pc, out_inst, out_ctrl, out_delayslot} !== {m_out.pc, m_out.inst, m_out.ctrl, m_ds}) begin
          errors++;
          $display("FAIL rand_out: got %0h expected %0h at cycle %0d",
                   {out_pc, out_inst, out_ctrl, out_delayslot},
                   {m_out.pc, m_out.inst, m_out.ctrl, m_ds}, cyc);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
